// File: rtl/multdiv_unit.sv
// multdiv_unit: multicycle signed multiply/divide for the execute stage.
// Multiply is radix-2 Booth, divide is non-restoring on magnitudes; both
// take WIDTH iterations and report through a one-cycle ready strobe.
// Optional feature macro: MULTDIV_DIV_EN (divider datapath and DIV state).
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef MULTDIV_DIV_EN
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
`endif

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic              illegal_pend;
  logic              start_mul, start_bad, start_any, busy, iter_done;
  logic [WIDTH-1:0]  res_n;
  logic              exc_n;

  // Booth accumulator: one guard bit on the upper half so that
  // subtracting the most negative multiplicand cannot corrupt the sign.
  logic signed [WIDTH:0] booth_a, booth_m, booth_sum;
  logic [WIDTH-1:0]      booth_q;
  logic                  booth_q1;

`ifdef MULTDIV_DIV_EN
  logic                    start_div;
  logic signed [WIDTH+1:0] div_r, div_r_sh, div_r_new, div_d_ext;
  logic [WIDTH-1:0]        div_q, div_d;
  logic                    div_neg, div_zero;
`endif

  // Signed overflow of the low-word product: bits [2W-1:W-1] must agree.
  function automatic logic mul_ovf(input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo);
    logic [WIDTH:0] top;
    top = {hi, lo[WIDTH-1]};
    return !((&top) | ~(|top));
  endfunction

`ifdef MULTDIV_DIV_EN
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  // Sign fix-up of the magnitude quotient; returns {exception, quotient}.
  // A positive quotient with its MSB set only arises from INT_MIN / -1.
  function automatic logic [WIDTH:0] div_fixup(input logic [WIDTH-1:0] q_mag,
                                               input logic neg, input logic zero);
    if (zero)     return {1'b1, {WIDTH{1'b0}}};
    else if (neg) return {1'b0, ~q_mag + 1'b1};
    else          return {q_mag[WIDTH-1], q_mag};
  endfunction
`endif

  // Start decode: a dual strobe, or DIV without a divider, is illegal.
  always_comb begin
    start_mul = ctrl_MULT & ~ctrl_DIV;
`ifdef MULTDIV_DIV_EN
    start_div = ctrl_DIV & ~ctrl_MULT;
    start_bad = ctrl_MULT & ctrl_DIV;
    start_any = start_mul | start_div | start_bad;
    busy      = (state == MULT) || (state == DIV);
`else
    start_bad = ctrl_DIV;
    start_any = start_mul | start_bad;
    busy      = (state == MULT);
`endif
    iter_done = (cnt == CW'(WIDTH));
  end

  // Next state; any start edge overrides whatever is in flight.
  always_comb begin
    state_n = state;
    if (start_mul)      state_n = MULT;
`ifdef MULTDIV_DIV_EN
    else if (start_div) state_n = DIV;
`endif
    else if (start_bad) state_n = IDLE;
    else begin
      case (state)
        IDLE:    if (illegal_pend) state_n = DONE;
        DONE:    state_n = IDLE;
        default: if (iter_done) state_n = DONE;
      endcase
    end
  end

  // Result selection for entry into DONE; the illegal path yields 0 / 1.
  always_comb begin
    res_n = '0;
    exc_n = 1'b1;
    if (state == MULT) begin
      res_n = booth_q;
      exc_n = mul_ovf(booth_a[WIDTH-1:0], booth_q);
    end
`ifdef MULTDIV_DIV_EN
    else if (state == DIV) begin
      {exc_n, res_n} = div_fixup(div_q, div_neg, div_zero);
    end
`endif
  end

  // Control and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      illegal_pend   <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state          <= state_n;
      illegal_pend   <= start_bad;
      data_resultRDY <= (state_n == DONE);
      if (start_any)              cnt <= '0;
      else if (busy && !iter_done) cnt <= cnt + CW'(1);
      if (state_n == DONE) begin
        data_result    <= res_n;
        data_exception <= exc_n;
      end
    end
  end

  // Booth step: add/sub selected by {q0, q-1}.
  always_comb begin
    booth_sum = booth_a;
    case ({booth_q[0], booth_q1})
      2'b01:   booth_sum = booth_a + booth_m;
      2'b10:   booth_sum = booth_a - booth_m;
      default: ;
    endcase
  end

  // Booth accumulator load and arithmetic right shift.
  always_ff @(posedge clock) begin
    if (start_mul) begin
      booth_a  <= '0;
      booth_q  <= data_operandB;
      booth_q1 <= 1'b0;
      booth_m  <= {data_operandA[WIDTH-1], data_operandA};
    end else if (state == MULT && !iter_done) begin
      {booth_a, booth_q, booth_q1} <= {booth_sum[WIDTH], booth_sum, booth_q};
    end
  end

`ifdef MULTDIV_DIV_EN
  // Non-restoring step: subtract when the partial remainder is
  // non-negative, add otherwise; quotient bit is the new sign inverted.
  always_comb begin
    div_d_ext = {2'b00, div_d};
    div_r_sh  = {div_r[WIDTH:0], div_q[WIDTH-1]};
    div_r_new = div_r[WIDTH+1] ? (div_r_sh + div_d_ext) : (div_r_sh - div_d_ext);
  end

  // Divider operand load and iteration.
  always_ff @(posedge clock) begin
    if (start_div) begin
      div_r    <= '0;
      div_q    <= magnitude(data_operandA);
      div_d    <= magnitude(data_operandB);
      div_neg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero <= (data_operandB == '0);
    end else if (state == DIV && !iter_done) begin
      div_r <= div_r_new;
      div_q <= {div_q[WIDTH-2:0], ~div_r_new[WIDTH+1]};
    end
  end
`endif

endmodule

// File: tb/tb_multdiv_unit.sv
// Randomized scoreboard bench for multdiv_unit (WIDTH = 32).
module tb_multdiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
    string       name;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  multdiv_unit #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  // Reference: kind 0 = multiply, 1 = divide, 2 = both strobes.
  function automatic exp_t model(input int kind, input logic [31:0] a, input logic [31:0] b,
                                 input int s);
    exp_t   e;
    longint p;
    int     qa, qb, q;
    e.due = s + LAT;
    if (kind == 0) begin
      e.name = "mul";
      p = longint'($signed(a)) * longint'($signed(b));
      e.res = p[31:0];
      e.exc = (p != longint'($signed(p[31:0])));
    end else if (kind == 1) begin
      e.name = "div";
`ifdef MULTDIV_DIV_EN
      qa = $signed(a);
      qb = $signed(b);
      if (b == 32'h0) begin
        e.res = 32'h0; e.exc = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.res = 32'h8000_0000; e.exc = 1'b1;
      end else begin
        q = qa / qb;
        e.res = q; e.exc = 1'b0;
      end
`else
      qa = 0; qb = 0; q = 0;
      e.res = 32'h0; e.exc = 1'b1; e.due = s + 1;
`endif
    end else begin
      e.name = "dual";
      e.res = 32'h0; e.exc = 1'b1; e.due = s + 1;
    end
    return e;
  endfunction

  // Called at posedge+1; the strobe is sampled on the next edge.
  task automatic issue(input int kind, input logic [31:0] a, input logic [31:0] b);
    int s;
    s = cyc + 1;
    while (sb.size() > 0 && sb[sb.size()-1].due >= s) void'(sb.pop_back());
    sb.push_back(model(kind, a, b, s));
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = (kind != 1);
    ctrl_DIV  = (kind != 0);
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL wait_timeout: %0d results pending after 100 cycles, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    total++;
    if (data_result !== 32'h0) begin
      bad++; $display("FAIL %s_result: got %h, required 00000000", tag, data_result);
    end
    total++;
    if (data_exception !== 1'b0) begin
      bad++; $display("FAIL %s_exc: got %b, required 0", tag, data_exception);
    end
    total++;
    if (data_resultRDY !== 1'b0) begin
      bad++; $display("FAIL %s_rdy: got %b, required 0", tag, data_resultRDY);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a ready pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) continue;
      if (sb.size() > 0 && cyc > sb[0].due) begin
        total++; bad++;
        $display("FAIL %s_missing: no ready by cycle %0d, now %0d", sb[0].name, sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (data_resultRDY) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ready: ready at cycle %0d, required none", cyc);
        end else begin
          e = sb.pop_front();
          total++;
          if (data_result !== e.res) begin
            bad++; $display("FAIL %s_result: got %h, required %h", e.name, data_result, e.res);
          end
          total++;
          if (data_exception !== e.exc) begin
            bad++; $display("FAIL %s_exc: got %b, required %b", e.name, data_exception, e.exc);
          end
          total++;
          if (cyc != e.due) begin
            bad++; $display("FAIL %s_latency: ready at cycle %0d, required %0d", e.name, cyc, e.due);
          end
        end
      end
    end
  end

  initial begin
    int hits;
    int r, kind;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero_outputs("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // Directed cases
    issue(0, 32'd7, -32'sd3);                 wait_idle();
    issue(0, 32'h0001_0000, 32'h0001_0000);   wait_idle();
    issue(0, 32'h7FFF_FFFF, 32'h1);           wait_idle();
    issue(1, -32'sd7, 32'd2);                 wait_idle();
    issue(1, 32'd5, 32'd0);                   wait_idle();
    issue(1, 32'h8000_0000, 32'hFFFF_FFFF);   wait_idle();
    issue(2, 32'd9, 32'd3);                   wait_idle();
    issue(1, 32'd8, 32'd2);                   wait_idle();

    // Abort: second start five edges after the first
    issue(0, 32'd3, 32'd4);
    repeat (4) begin @(posedge clock); #1; end
    issue(1, 32'd100, 32'd7);
    wait_idle();

    // Back-to-back: new start sampled during the DONE cycle
    issue(0, 32'd11, 32'd13);
    repeat (LAT) begin @(posedge clock); #1; end
    issue(0, -32'sd5, 32'd6);
    wait_idle();

    // Asynchronous reset in the middle of a multiply
    issue(0, 32'd5, 32'd6);
    repeat (9) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    sb.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    hits = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) hits++;
    end
    total++;
    if (hits != 0) begin
      bad++; $display("FAIL post_reset_quiet: got %0d ready pulses, required 0", hits);
    end
    @(posedge clock); #1;
    issue(0, 32'd2, 32'd2);
    wait_idle();

    // Randomized mix with occasional aborts
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 19);
      kind = (r < 9) ? 0 : (r < 18) ? 1 : 2;
      issue(kind, pick(), pick());
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 36)) begin @(posedge clock); #1; end
      end else begin
        wait_idle();
      end
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
